// File: rtl/ysyx_24110006_exu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_exu_pkg
// Purpose  : Shared definitions for the execute stage: ALU one-hot bit
//            positions and width, branch/jump encodings, operand-B select
//            encodings and the memory-op field width.
// Ports    : (package, none)
// Options  : YSYX_24110006_EXU_PERF_EN (used by the interface and top)
// Revision : 1.0  initial release
// ============================================================================
package ysyx_24110006_exu_pkg;

    // One-hot ALU operation vector, bit order ADD..AND
    localparam int ALU_TYPE = 8;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SLL  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_XOR  = 3;
    localparam int ALU_SRL  = 4;
    localparam int ALU_SRA  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_AND  = 7;

    localparam int MEM_OP_W = 4;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_JAL  = 3'd5,
        BR_JALR = 3'd6
    } br_e;

    typedef enum logic [1:0] {
        BSEL_RS2  = 2'd0,
        BSEL_IMM  = 2'd1,
        BSEL_FOUR = 2'd2
    } bsel_e;

    // Conditional branches never write a destination register
    function automatic logic br_is_cond(input br_e br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) || (br == BR_BGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24110006_exu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_exu_if
// Purpose  : Bundles the IDU->EXU request channel and the EXU->LSU result
//            channel plus the redirect outputs.
//            slave  : EXU view (i_* inputs, o_* outputs)
//            master : environment view (drives i_*, observes o_*)
// Options  : YSYX_24110006_EXU_PERF_EN adds o_perf_insn/redirect/stall
// Revision : 1.0  initial release
// ============================================================================
interface ysyx_24110006_exu_if #(
    parameter int XLEN = 32
) ();
    import ysyx_24110006_exu_pkg::*;

    // IDU -> EXU
    logic                i_valid;
    logic                o_ready;
    logic [XLEN-1:0]     i_pc;
    logic [XLEN-1:0]     i_rs1;
    logic [XLEN-1:0]     i_rs2;
    logic [XLEN-1:0]     i_imm;
    logic [ALU_TYPE-1:0] i_alu_t;
    logic                i_sub;
    logic                i_sign;
    logic                i_asel_pc;
    logic [1:0]          i_bsel;
    logic [2:0]          i_br;
    logic [4:0]          i_rd;
    logic                i_wen;
    logic [MEM_OP_W-1:0] i_mem_op;

    // EXU -> LSU
    logic                o_valid;
    logic                i_ready;
    logic [XLEN-1:0]     o_result;
    logic [XLEN-1:0]     o_sdata;
    logic [4:0]          o_rd;
    logic                o_wen;
    logic [MEM_OP_W-1:0] o_mem_op;

    // EXU -> IFU/IDU
    logic                o_redirect;
    logic [XLEN-1:0]     o_target;

`ifdef YSYX_24110006_EXU_PERF_EN
    logic [31:0]         o_perf_insn;
    logic [31:0]         o_perf_redirect;
    logic [31:0]         o_perf_stall;
`endif

    modport slave (
        input  i_valid, i_pc, i_rs1, i_rs2, i_imm, i_alu_t, i_sub, i_sign,
               i_asel_pc, i_bsel, i_br, i_rd, i_wen, i_mem_op, i_ready,
        output o_ready, o_valid, o_result, o_sdata, o_rd, o_wen, o_mem_op,
               o_redirect, o_target
`ifdef YSYX_24110006_EXU_PERF_EN
        , output o_perf_insn, o_perf_redirect, o_perf_stall
`endif
    );

    modport master (
        output i_valid, i_pc, i_rs1, i_rs2, i_imm, i_alu_t, i_sub, i_sign,
               i_asel_pc, i_bsel, i_br, i_rd, i_wen, i_mem_op, i_ready,
        input  o_ready, o_valid, o_result, o_sdata, o_rd, o_wen, o_mem_op,
               o_redirect, o_target
`ifdef YSYX_24110006_EXU_PERF_EN
        , input o_perf_insn, o_perf_redirect, o_perf_stall
`endif
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_24110006_bru.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_bru
// Purpose  : Combinational branch-resolve unit. Derives the less-than flag
//            from the shared ALU adder, decides taken, and computes the
//            redirect target with its own adder.
// Ports    : i_sum/i_carry  shared adder result (A + ~B + 1 for compares)
//            i_sign         signed compare when 1
//            i_a_msb/i_b_msb sign bits of operands A and B
//            i_br           branch/jump kind
//            i_pc/i_rs1/i_imm target base and offset
//            o_taken, o_target, o_lt
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24110006_bru
    import ysyx_24110006_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_sum,
    input  logic            i_carry,
    input  logic            i_sign,
    input  logic            i_a_msb,
    input  logic            i_b_msb,
    input  br_e             i_br,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target,
    output logic            o_lt
);

    logic            w_eq;
    logic            w_lt_s;
    logic            w_is_jalr;
    logic [XLEN-1:0] w_tsum;

    assign w_eq   = (i_sum == '0);
    // Differing signs decide directly; otherwise the difference sign is exact
    assign w_lt_s = (i_a_msb != i_b_msb) ? i_a_msb : i_sum[XLEN-1];
    // Unsigned: no carry out of A + ~B + 1 means a borrow, i.e. A < B
    assign o_lt   = i_sign ? w_lt_s : ~i_carry;

    always_comb begin
        o_taken = 1'b0;
        case (i_br)
            BR_BEQ:  o_taken = w_eq;
            BR_BNE:  o_taken = ~w_eq;
            BR_BLT:  o_taken = o_lt;
            BR_BGE:  o_taken = ~o_lt;
            BR_JAL:  o_taken = 1'b1;
            BR_JALR: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

    assign w_is_jalr = (i_br == BR_JALR);
    assign w_tsum    = (w_is_jalr ? i_rs1 : i_pc) + i_imm;
    assign o_target  = w_tsum & {{(XLEN-1){1'b1}}, ~w_is_jalr};

endmodule
`default_nettype wire

// File: rtl/ysyx_24110006_exu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_exu
// Purpose  : Execute stage. Selects ALU operands, evaluates the one-hot ALU,
//            resolves branches/jumps and registers the result plus
//            pass-through control into a one-entry buffer toward LSU.
//            A taken branch/jump raises a one-cycle o_redirect pulse.
// Ports    : clock  core clock
//            reset  synchronous, active-low
//            bus    ysyx_24110006_exu_if.slave (IDU request, LSU result,
//                   redirect, optional perf counters)
// Options  : YSYX_24110006_EXU_PERF_EN enables instruction/redirect/stall
//            counters on o_perf_insn/o_perf_redirect/o_perf_stall
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24110006_exu
    import ysyx_24110006_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clock,
    input  logic               reset,
    ysyx_24110006_exu_if.slave bus
);

    // ---------------- operand selection and shared adder ----------------
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_b_add;
    logic [XLEN-1:0] w_sum;
    logic            w_carry;
    logic [4:0]      w_shamt;
    br_e             w_br;

    assign w_br = br_e'(bus.i_br);
    assign w_a  = bus.i_asel_pc ? bus.i_pc : bus.i_rs1;

    always_comb begin
        w_b = '0;
        case (bsel_e'(bus.i_bsel))
            BSEL_RS2:  w_b = bus.i_rs2;
            BSEL_IMM:  w_b = bus.i_imm;
            BSEL_FOUR: w_b = XLEN'(4);
            default:   w_b = '0;
        endcase
    end

    assign w_b_add          = bus.i_sub ? ~w_b : w_b;
    assign {w_carry, w_sum} = {1'b0, w_a} + {1'b0, w_b_add} + {{XLEN{1'b0}}, bus.i_sub};
    assign w_shamt          = w_b[4:0];

    // ---------------- branch resolve ----------------
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_lt;

    ysyx_24110006_bru #(
        .XLEN (XLEN)
    ) u_bru (
        .i_sum    (w_sum),
        .i_carry  (w_carry),
        .i_sign   (bus.i_sign),
        .i_a_msb  (w_a[XLEN-1]),
        .i_b_msb  (w_b[XLEN-1]),
        .i_br     (w_br),
        .i_pc     (bus.i_pc),
        .i_rs1    (bus.i_rs1),
        .i_imm    (bus.i_imm),
        .o_taken  (w_taken),
        .o_target (w_target),
        .o_lt     (w_lt)
    );

    // ---------------- one-hot ALU result ----------------
    logic [XLEN-1:0] w_op [ALU_TYPE];
    logic [XLEN-1:0] w_result;

    always_comb begin
        w_op[ALU_ADD] = w_sum;
        w_op[ALU_SLL] = w_a << w_shamt;
        w_op[ALU_SLT] = {{(XLEN-1){1'b0}}, w_lt};
        w_op[ALU_XOR] = w_a ^ w_b;
        w_op[ALU_SRL] = w_a >> w_shamt;
        w_op[ALU_SRA] = $signed(w_a) >>> w_shamt;
        w_op[ALU_OR]  = w_a | w_b;
        w_op[ALU_AND] = w_a & w_b;
    end

    // AND-OR select: an all-zero op vector produces zero
    always_comb begin
        w_result = '0;
        for (int k = 0; k < ALU_TYPE; k++) begin
            w_result = w_result | ({XLEN{bus.i_alu_t[k]}} & w_op[k]);
        end
    end

    // ---------------- output register ----------------
    logic                r_valid;
    logic                r_redirect;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_sdata;
    logic [XLEN-1:0]     r_target;
    logic [4:0]          r_rd;
    logic                r_wen;
    logic [MEM_OP_W-1:0] r_mem_op;
    logic                w_ready;
    logic                w_accept;

    // Blocking intake during the redirect cycle drops the wrong-path instruction
    assign w_ready  = (~r_valid | bus.i_ready) & ~r_redirect;
    assign w_accept = bus.i_valid & w_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_redirect <= 1'b0;
            r_result   <= '0;
            r_sdata    <= '0;
            r_target   <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_mem_op   <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_redirect <= w_taken;
            r_result   <= w_result;
            r_sdata    <= bus.i_rs2;
            r_target   <= w_target;
            r_rd       <= bus.i_rd;
            r_wen      <= bus.i_wen & ~br_is_cond(w_br);
            r_mem_op   <= bus.i_mem_op;
        end else begin
            // The redirect is a pulse even if the result is stalled
            r_redirect <= 1'b0;
            if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = r_valid;
    assign bus.o_redirect = r_redirect;
    assign bus.o_result   = r_result;
    assign bus.o_sdata    = r_sdata;
    assign bus.o_target   = r_target;
    assign bus.o_rd       = r_rd;
    assign bus.o_wen      = r_wen;
    assign bus.o_mem_op   = r_mem_op;

`ifdef YSYX_24110006_EXU_PERF_EN
    // ---------------- performance counters (wrap on overflow) ----------------
    logic [31:0] r_perf_insn;
    logic [31:0] r_perf_redirect;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_insn     <= '0;
            r_perf_redirect <= '0;
            r_perf_stall    <= '0;
        end else begin
            if (w_accept) begin
                r_perf_insn <= r_perf_insn + 32'd1;
            end
            if (r_redirect) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
            if (r_valid && !bus.i_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.o_perf_insn     = r_perf_insn;
    assign bus.o_perf_redirect = r_perf_redirect;
    assign bus.o_perf_stall    = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_exu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24110006_exu
// Purpose  : Directed self-checking bench for ysyx_24110006_exu. Inputs
//            change and outputs are checked 1 time unit after each rising
//            clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24110006_exu;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    ysyx_24110006_exu_if #(.XLEN(32)) bus ();

    ysyx_24110006_exu #(.XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [7:0] alu, input logic sub, input logic sign,
                          input logic asel, input logic [1:0] bsel, input logic [2:0] br,
                          input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
        bus.i_alu_t   = alu;
        bus.i_sub     = sub;
        bus.i_sign    = sign;
        bus.i_asel_pc = asel;
        bus.i_bsel    = bsel;
        bus.i_br      = br;
        bus.i_pc      = pc;
        bus.i_rs1     = rs1;
        bus.i_rs2     = rs2;
        bus.i_imm     = imm;
    endtask

    // Accept one instruction with LSU ready, then drop i_valid
    task automatic issue();
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_rd     = 5'd3;
        bus.i_wen    = 1'b1;
        bus.i_mem_op = 4'hA;
        set_op(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        chk("rst_valid",    {31'b0, bus.o_valid},    32'd0);
        chk("rst_redirect", {31'b0, bus.o_redirect}, 32'd0);
        chk("rst_result",   bus.o_result,            32'd0);
        chk("rst_ready",    {31'b0, bus.o_ready},    32'd1);

        // ADD 5 + 7
        set_op(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0);
        issue();
        chk("add_valid",    {31'b0, bus.o_valid},    32'd1);
        chk("add_result",   bus.o_result,            32'd12);
        chk("add_redirect", {31'b0, bus.o_redirect}, 32'd0);
        chk("add_ready",    {31'b0, bus.o_ready},    32'd1);
        chk("add_sdata",    bus.o_sdata,             32'd7);
        chk("add_rd",       {27'b0, bus.o_rd},       32'd3);
        chk("add_memop",    {28'b0, bus.o_mem_op},   32'hA);

        // BLT signed: -1 < 1 taken
        set_op(8'h01, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h10);
        issue();
        chk("blt_redirect", {31'b0, bus.o_redirect}, 32'd1);
        chk("blt_target",   bus.o_target,            32'h80000010);
        chk("blt_ready",    {31'b0, bus.o_ready},    32'd0);
        chk("blt_wen",      {31'b0, bus.o_wen},      32'd0);
        chk("blt_valid",    {31'b0, bus.o_valid},    32'd1);
        tick();
        chk("blt_pulse",    {31'b0, bus.o_redirect}, 32'd0);
        chk("blt_drained",  {31'b0, bus.o_valid},    32'd0);

        // BLTU: 0xFFFFFFFF < 1 unsigned is false
        set_op(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h10);
        issue();
        chk("bltu_redirect", {31'b0, bus.o_redirect}, 32'd0);
        chk("bltu_ready",    {31'b0, bus.o_ready},    32'd1);

        // BGE signed: -1 >= 1 false
        set_op(8'h01, 1'b1, 1'b1, 1'b0, 2'd0, 3'd4, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h10);
        issue();
        chk("bge_redirect", {31'b0, bus.o_redirect}, 32'd0);

        // BEQ taken with a negative offset
        set_op(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 32'h100, 32'd9, 32'd9, 32'hFFFFFFF0);
        issue();
        chk("beq_redirect", {31'b0, bus.o_redirect}, 32'd1);
        chk("beq_target",   bus.o_target,            32'h000000F0);
        tick();

        // BNE on equal operands: not taken
        set_op(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 32'h100, 32'd9, 32'd9, 32'h40);
        issue();
        chk("bne_redirect", {31'b0, bus.o_redirect}, 32'd0);

        // JALR: target clears bit 0, result is pc + 4, wen passes
        bus.i_rd = 5'd1;
        set_op(8'h01, 1'b0, 1'b0, 1'b1, 2'd2, 3'd6, 32'h80000020, 32'h80000103, 32'h0, 32'h0);
        issue();
        chk("jalr_redirect", {31'b0, bus.o_redirect}, 32'd1);
        chk("jalr_target",   bus.o_target,            32'h80000102);
        chk("jalr_result",   bus.o_result,            32'h80000024);
        chk("jalr_wen",      {31'b0, bus.o_wen},      32'd1);
        chk("jalr_rd",       {27'b0, bus.o_rd},       32'd1);
        tick();

        // JAL
        set_op(8'h01, 1'b0, 1'b0, 1'b1, 2'd2, 3'd5, 32'h1000, 32'h0, 32'h0, 32'h800);
        issue();
        chk("jal_target", bus.o_target, 32'h1800);
        chk("jal_result", bus.o_result, 32'h1004);
        tick();

        // Backpressure: hold 0x10+0x20 for 3 cycles, then drain+accept SUB 100-1
        set_op(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h10, 32'h20, 32'h0);
        issue();
        bus.i_ready = 1'b0;
        set_op(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'd100, 32'd1, 32'h0);
        bus.i_valid = 1'b1;
        #1;
        chk("bp_ready0", {31'b0, bus.o_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_result", bus.o_result,         32'h30);
            chk("bp_hold_valid",  {31'b0, bus.o_valid}, 32'd1);
            chk("bp_hold_ready",  {31'b0, bus.o_ready}, 32'd0);
        end
        bus.i_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, bus.o_ready}, 32'd1);
        tick();
        bus.i_valid = 1'b0;
        chk("bp_swap_valid",  {31'b0, bus.o_valid}, 32'd1);
        chk("bp_swap_result", bus.o_result,         32'd99);

        // Shifts: amount uses B[4:0] only
        set_op(8'h20, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 32'h0, 32'h80000000, 32'h0, 32'h24);
        issue();
        chk("sra_result", bus.o_result, 32'hF8000000);
        set_op(8'h10, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 32'h0, 32'h80000000, 32'h0, 32'h24);
        issue();
        chk("srl_result", bus.o_result, 32'h08000000);
        set_op(8'h02, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 32'h0, 32'h00000003, 32'h0, 32'h21);
        issue();
        chk("sll_result", bus.o_result, 32'h00000006);

        // SLT / SLTU of -1 vs 1
        set_op(8'h04, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
        issue();
        chk("slt_result", bus.o_result, 32'd1);
        set_op(8'h04, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0);
        issue();
        chk("sltu_result", bus.o_result, 32'd0);

        // Logic ops and all-zero op vector
        set_op(8'h08, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
        issue();
        chk("xor_result", bus.o_result, 32'h0FF00FF0);
        set_op(8'h80, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
        issue();
        chk("and_result", bus.o_result, 32'hF000F000);
        set_op(8'h40, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
        issue();
        chk("or_result", bus.o_result, 32'hFFF0FFF0);
        set_op(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0);
        issue();
        chk("none_result", bus.o_result, 32'd0);

        // Reset while holding a taken jump
        set_op(8'h01, 1'b0, 1'b0, 1'b1, 2'd2, 3'd5, 32'h2000, 32'h0, 32'h0, 32'h100);
        issue();
        chk("prerst_redirect", {31'b0, bus.o_redirect}, 32'd1);
        chk("prerst_valid",    {31'b0, bus.o_valid},    32'd1);
        reset = 1'b0;
        tick();
        chk("rst2_valid",    {31'b0, bus.o_valid},    32'd0);
        chk("rst2_redirect", {31'b0, bus.o_redirect}, 32'd0);
        chk("rst2_result",   bus.o_result,            32'd0);
        chk("rst2_target",   bus.o_target,            32'd0);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
